// File: rtl/dac_spi_driver.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_driver
//  Description : Serialises the 16-bit DDS sample into an external SPI DAC.
//                Each frame carries a CMD_BITS-wide command prefix followed by
//                the sample, sent MSB-first in SPI mode 0 (CPOL = 0,
//                CPHA = 0). Frames repeat back-to-back while 'enable' is high.
//                An optional LDAC strobe tells the DAC to update its output
//                after each frame.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Build option:
//    DAC_SPI_LDAC_EN  defined   -> LDAC state present. dac_ldac_n pulses low
//                                  for CLK_DIV cycles after every frame.
//                     undefined -> no LDAC state. dac_ldac_n is tied to 1 and
//                                  the DAC updates itself on the dac_cs_n rise.
// ----------------------------------------------------------------------------
//  Parameters:
//    CLK_DIV     SCLK half-period in clk cycles (>= 1)
//    CMD_BITS    command prefix width (>= 1)
//    CMD_WORD    command prefix value, sent before the sample
//    GAP_CYCLES  minimum dac_cs_n high time between frames (>= 1)
//  Ports:
//    clk           in   system clock (shared with the DDS)
//    reset         in   asynchronous, active-low reset
//    sample_in     in   16-bit DDS sample word
//    enable        in   level; frames run while high
//    dac_sclk      out  SPI clock, idles low
//    dac_din       out  SPI data, changes only while SCLK is low
//    dac_cs_n      out  frame chip-select, active-low
//    dac_ldac_n    out  DAC load strobe, active-low
//    sample_taken  out  one-cycle pulse when sample_in is latched
//    busy          out  high whenever the FSM is not idle
// ============================================================================
module dac_spi_driver #(
    parameter int unsigned         CLK_DIV    = 2,
    parameter int unsigned         CMD_BITS   = 8,
    parameter logic [CMD_BITS-1:0] CMD_WORD   = 8'h30,
    parameter int unsigned         GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        enable,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        dac_cs_n,
    output logic        dac_ldac_n,
    output logic        sample_taken,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int unsigned N     = CMD_BITS + 16;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(N);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
`ifdef DAC_SPI_LDAC_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LDAC  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd3
    } state_t;
`endif

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [N-1:0]     shreg_q,    shreg_d;
    logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
    logic             sclk_q,     sclk_d;
    logic             din_q,      din_d;
    logic             cs_n_q,     cs_n_d;
    logic             taken_q,    taken_d;
    logic             busy_q,     busy_d;
`ifdef DAC_SPI_LDAC_EN
    logic             ldac_n_q,   ldac_n_d;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sclk_d    = sclk_q;
        din_d     = din_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        taken_d   = 1'b0;
`ifdef DAC_SPI_LDAC_EN
        ldac_n_d  = ldac_n_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Idle values are re-asserted every cycle so the bus is
                // clean regardless of how the previous frame ended.
                sclk_d = 1'b0;
                din_d  = 1'b0;
                cs_n_d = 1'b1;
                busy_d = 1'b0;
                if (enable) begin
                    // The first bit is presented together with the CS fall
                    // so it is set up a full half-period before SCLK rises.
                    shreg_d   = {CMD_WORD, sample_in};
                    din_d     = CMD_WORD[CMD_BITS-1];
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    taken_d   = 1'b1;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (sclk_q) begin
                        // SCLK high->low: the DAC has sampled the current
                        // bit on the preceding rise, so move to the next one.
                        if (bit_cnt_q == BIT_LAST) begin
                            // Last falling edge closes the frame; CS and the
                            // data line return to idle in the same cycle.
                            bit_cnt_d = '0;
                            cs_n_d    = 1'b1;
                            din_d     = 1'b0;
                            gap_cnt_d = '0;
`ifdef DAC_SPI_LDAC_EN
                            ldac_n_d  = 1'b0;
                            state_d   = ST_LDAC;
`else
                            state_d   = ST_GAP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            // Rotate rather than shift so every register bit
                            // stays live; the register is reloaded per frame.
                            shreg_d   = {shreg_q[N-2:0], shreg_q[N-1]};
                            din_d     = shreg_q[N-2];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

`ifdef DAC_SPI_LDAC_EN
            ST_LDAC: begin
                // The divider is already at zero on entry, so it times the
                // strobe width in CLK_DIV cycles.
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    ldac_n_d  = 1'b1;
                    state_d   = ST_GAP;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
`endif

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                sclk_d    = 1'b0;
                din_d     = 1'b0;
                cs_n_d    = 1'b1;
                busy_d    = 1'b0;
                div_cnt_d = '0;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sclk_q    <= 1'b0;
            din_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            taken_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef DAC_SPI_LDAC_EN
            ldac_n_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            cs_n_q    <= cs_n_d;
            taken_q   <= taken_d;
            busy_q    <= busy_d;
`ifdef DAC_SPI_LDAC_EN
            ldac_n_q  <= ldac_n_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven straight from flops)
    // ------------------------------------------------------------------------
    assign dac_sclk     = sclk_q;
    assign dac_din      = din_q;
    assign dac_cs_n     = cs_n_q;
    assign sample_taken = taken_q;
    assign busy         = busy_q;
`ifdef DAC_SPI_LDAC_EN
    assign dac_ldac_n   = ldac_n_q;
`else
    assign dac_ldac_n   = 1'b1;
`endif

endmodule
`default_nettype wire

// File: doc/dac_spi_driver.md
# dac_spi_driver

Serialises the 16-bit DDS output word (the selected waveform sample on `SignalOut`) into an external SPI DAC. Sits directly downstream of the DDS top level and runs on the same system clock. It latches one sample per frame, shifts a command byte plus the sample MSB-first in SPI mode 0, and optionally strobes the DAC's LDAC pin to update the output. Frames repeat back-to-back while `enable` is high, so the DAC update rate is fixed by the parameters below.

## Interface

Parameters:
- `CLK_DIV`, 2: SCLK half-period in `clk` cycles; must be ≥ 1.
- `CMD_BITS`, 8: command-prefix width; must be ≥ 1.
- `CMD_WORD`, 8'h30: command prefix, sent MSB-first before the sample.
- `GAP_CYCLES`, 4: minimum `dac_cs_n` high time between frames, in `clk` cycles; must be ≥ 1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `sample_in` in 16: DDS sample word.
- `enable` in 1: level; frames run while high.
- `dac_sclk` out 1: SPI clock, CPOL = 0.
- `dac_din` out 1: SPI data, changes only while SCLK is low.
- `dac_cs_n` out 1: frame chip-select, active-low.
- `dac_ldac_n` out 1: DAC load strobe, active-low.
- `sample_taken` out 1: one-cycle pulse when `sample_in` is latched.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation

- Frame length is N = CMD_BITS + 16 bits. The shift register is N bits wide.
- All outputs are registered and glitch-free.
- Reset values: `dac_sclk` = 0, `dac_din` = 0, `dac_cs_n` = 1, `dac_ldac_n` = 1, `sample_taken` = 0, `busy` = 0, FSM = IDLE, all counters = 0.
- **IDLE:**
  - If `enable` is 1 at a clock edge, load shreg = {CMD_WORD, sample_in}.
  - Pulse `sample_taken`, drive `dac_cs_n` = 0 and `dac_din` = shreg[N-1], then go to SHIFT.
  - Otherwise hold all outputs at their idle values.
- **SHIFT:**
  - A divider counts 0..CLK_DIV-1; at terminal count it toggles `dac_sclk`.
  - On each high→low transition, shift left and present the next MSB on `dac_din`.
  - A bit counter counts falling edges. After the N-th falling edge, `dac_cs_n` = 1 and `dac_din` = 0 in the same cycle.
  - Next state is LDAC if it is compiled in, otherwise GAP.
- **LDAC:** `dac_ldac_n` = 0 for exactly CLK_DIV cycles, then go to GAP.
- **GAP:** hold `dac_cs_n` high for GAP_CYCLES cycles, then go to IDLE. A new frame can start on the IDLE cycle that follows.
- `sample_in` changes after the latch are ignored until the next frame.
- Deasserting `enable` mid-frame does not abort the frame. It completes fully, then the block stays in IDLE.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). No partial frame resumes after release.

## Timing

- Let T be the edge that latches the sample (`sample_taken` high during cycle T+1).
- `dac_cs_n` falls at T+1, and the first data bit is valid from T+1.
- The k-th SCLK rising edge (k = 1..N) occurs at T+1+(2k-1)·CLK_DIV.
- `dac_cs_n` rises at T+1+2·N·CLK_DIV.
- `dac_ldac_n` is low for CLK_DIV cycles starting at the `dac_cs_n` rise (macro defined).
- Frame period with `enable` held high: P = 1 + 2·N·CLK_DIV + L + GAP_CYCLES, where L = CLK_DIV with LDAC compiled in and L = 0 without.
- With default parameters: P = 103 with LDAC, 101 without.
- `busy` rises with `dac_cs_n` and falls on entry to IDLE.

## Configuration

- Macro: `DAC_SPI_LDAC_EN`.
- **Defined:** the LDAC state exists and `dac_ldac_n` pulses low for CLK_DIV cycles after every frame.
- **Undefined:** the LDAC state is removed, `dac_ldac_n` is tied to 1, and SHIFT proceeds directly to GAP. The DAC is expected to self-update on the `dac_cs_n` rise.

## Test plan

- **Single frame, defaults, LDAC defined.** Stimulus: `sample_in` = 16'hA5C3, one-cycle `enable`. Required: bits captured on the 24 SCLK rising edges equal 24'h30A5C3; `dac_cs_n` low for 96 cycles; `dac_ldac_n` low for 2 cycles; exactly one `sample_taken` pulse.
- **Continuous run.** Stimulus: `enable` held high, `sample_in` incrementing every cycle. Required: `sample_taken` pulses every 103 cycles; each frame carries the value present at its latch edge.
- **Reset mid-frame.** Stimulus: assert `reset` low after the 10th SCLK rise. Required: `dac_cs_n` = 1, `dac_sclk` = 0, `busy` = 0 with no clock edge. After release with `enable` high, the next frame starts from bit 23.
- **Enable drop mid-frame.** Stimulus: `enable` goes low at bit 5. Required: all 24 bits shift out, the GAP completes, `busy` falls, and no second `sample_taken` occurs.
- **LDAC compiled out.** Stimulus: macro undefined, `enable` held high. Required: `dac_ldac_n` constantly 1 and frame period 101.
- **Fastest clocking.** Stimulus: CLK_DIV = 1, `sample_in` = 16'h0001. Required: SCLK = clk/2, `dac_cs_n` low for 48 cycles, and the final bit is 1.
